div_controller: RTL

//   Sequencer for the iterative radix-2 restoring divider that executes DIV/DIVU in EX.

---
 rtl/div_controller_pkg.sv | 11 +
 rtl/div_controller_step.sv | 18 +
 rtl/div_controller.sv | 88 ++++++++
 3 files changed

// File: rtl/div_controller_pkg.sv
// div_controller_pkg: shared FSM state encodings and decoder funct codes for the divide sequencer
package div_controller_pkg;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;
  localparam logic [5:0] EXE_DIV  = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;
endpackage

// File: rtl/div_controller_step.sv
// div_step: one combinational restoring shift/subtract iteration of the radix-2 divider
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh;
  logic ge;
  assign sh = {rem, quo[WIDTH-1]};
  assign ge = sh >= {1'b0, divisor};
  // rem < divisor holds between steps, so the restored or reduced value always fits WIDTH bits
  assign rem_n = ge ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_controller.sv
// div_controller: iterative restoring DIV/DIVU sequencer with pipeline stall and HI/LO result pulse.
// Defining DIV_ZERO_FLAG_EN adds the div_zero_o output flagging a zero divisor alongside ready_o.
module div_controller
  import div_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
`else
  output logic [2*WIDTH-1:0] result_o
`endif
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor, rem_n, quo_n, a_abs, b_abs;
  logic q_neg, r_neg, zero_r, b_zero;
  assign b_zero = opb_i == '0;
  assign a_abs = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign b_abs = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .quo(quo),
    .divisor(divisor),
    .rem_n(rem_n),
    .quo_n(quo_n)
  );
  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: state_n = (start_i && !annul_i) ? (b_zero ? DIV_ZERO : DIV_ON) : DIV_IDLE;
      DIV_ON:   state_n = annul_i ? DIV_IDLE : (cnt == CW'(WIDTH-1)) ? DIV_END : DIV_ON;
      DIV_ZERO: state_n = annul_i ? DIV_IDLE : DIV_END;
      default:  state_n = DIV_IDLE;
    endcase
  end
  assign stall_o = !rst && ((state == DIV_IDLE && start_i && !annul_i) || state == DIV_ON || state == DIV_ZERO);
  assign ready_o = state == DIV_END;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = ready_o && zero_r;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      zero_r   <= 1'b0;
      result_o <= '0;
    end else begin
      if (state == DIV_IDLE) begin
        cnt     <= '0;
        rem     <= '0;
        quo     <= b_zero ? opa_i : a_abs;
        divisor <= b_abs;
        q_neg   <= signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
        r_neg   <= signed_i && opa_i[WIDTH-1];
        zero_r  <= b_zero;
      end
      if (state == DIV_ON) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
      end
      // the result commits only on the edge that enters END, so an annul leaves it untouched
      if (state != DIV_END && state_n == DIV_END)
        result_o <= zero_r ? {quo, {WIDTH{1'b1}}}
                           : {r_neg ? -rem_n : rem_n, q_neg ? -quo_n : quo_n};
    end
  end
endmodule
